multicycle_main_fsm: RTL and testbench

//  Main control FSM for the multicycle RV32I core. Sequences the shared ALU, memory
//  and register file across FETCH/DECODE/EXECUTE/MEM/WB steps. Drives ALUOp into
//  alu_decoder and the datapath mux selects and enables. Stalls on memory not-ready.

---
 rtl/ctrl_pkg.sv | 54 +++++
 rtl/opcode_classifier.sv | 25 ++
 rtl/multicycle_main_fsm.sv | 141 ++++++++++++++
 tb/tb_multicycle_main_fsm.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I main control FSM: states, opcodes,
// ALUOp values, datapath mux selects and the decoded instruction class.
package ctrl_pkg;

    localparam int STATE_WIDTH = 4;

    typedef enum logic [STATE_WIDTH-1:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXEC_R   = 4'd7,
        S_EXEC_I   = 4'd8,
        S_ALUWB    = 4'd9,
        S_JAL      = 4'd10,
        S_BEQ      = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef enum logic [2:0] {
        CLS_MEM     = 3'd0,
        CLS_RTYPE   = 3'd1,
        CLS_ITYPE   = 3'd2,
        CLS_JAL     = 3'd3,
        CLS_BEQ     = 3'd4,
        CLS_ILLEGAL = 3'd5
    } instr_class_t;

endpackage

// File: rtl/opcode_classifier.sv
// Maps a 7-bit RV32I opcode onto the instruction class that picks the
// DECODE successor; loads and stores share one class until MEMADR.
module opcode_classifier
    import ctrl_pkg::*;
#(
    parameter int OP_WIDTH = 7
) (
    input  logic [OP_WIDTH-1:0] op_i,
    output instr_class_t        cls_o
);

    always_comb begin
        cls_o = CLS_ILLEGAL;
        case (op_i)
            OP_LOAD,
            OP_STORE: cls_o = CLS_MEM;
            OP_RTYPE: cls_o = CLS_RTYPE;
            OP_ITYPE: cls_o = CLS_ITYPE;
            OP_JAL:   cls_o = CLS_JAL;
            OP_BEQ:   cls_o = CLS_BEQ;
            default:  cls_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences the shared ALU,
// memory and register file and stalls while memory is not ready.
module multicycle_main_fsm
    import ctrl_pkg::*;
#(
    parameter int OP_WIDTH     = 7,
    parameter int ALU_OP_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OP_WIDTH-1:0]     op,
    input  logic                    zero,
    input  logic                    mem_ready,
    output logic                    pc_write,
    output logic                    adr_src,
    output logic                    mem_write,
    output logic                    ir_write,
    output logic [1:0]              result_src,
    output logic [1:0]              alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic                    reg_write,
    output logic                    illegal_op
);

    state_t       state_q;
    state_t       state_d;
    instr_class_t instr_cls;
    logic         pc_update;
    logic         branch;

    opcode_classifier #(
        .OP_WIDTH (OP_WIDTH)
    ) u_classifier (
        .op_i  (op),
        .cls_o (instr_cls)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_OP_WIDTH'(ALUOP_ADD);
        reg_write  = 1'b0;
        illegal_op = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;

        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                // PC and IR only move on the cycle the fetch actually completes
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = mem_ready;
                pc_update  = mem_ready;
                state_d    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (instr_cls)
                    CLS_MEM:   state_d = S_MEMADR;
                    CLS_RTYPE: state_d = S_EXEC_R;
                    CLS_ITYPE: state_d = S_EXEC_I;
                    CLS_JAL:   state_d = S_JAL;
                    CLS_BEQ:   state_d = S_BEQ;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                state_d   = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALU_OP_WIDTH'(ALUOP_FUNCT);
                state_d   = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_OP_WIDTH'(ALUOP_FUNCT);
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALU_OP_WIDTH'(ALUOP_SUB);
                branch    = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign pc_write = pc_update | (branch & zero);

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Scoreboard bench: the driver queues the expected output vector for each
// cycle it drives; a negedge monitor pops and compares against the DUT.
module tb_multicycle_main_fsm;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

    multicycle_main_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write, adr_src, mem_write, ir_write, result_src, a, b, alu_op, reg_write, illegal_op}
    function automatic logic [13:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] rs,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] aop, input logic rw,
                                       input logic ill);
        return {pcw, adr, mw, irw, rs, a, b, aop, rw, ill};
    endfunction

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b0001111;

    logic [13:0] e_zero, e_fetch, e_fetch_stall, e_decode, e_decode_ill, e_memadr;
    logic [13:0] e_memread, e_memwb, e_memwrite, e_exec_r, e_exec_i, e_aluwb, e_jal;
    logic [13:0] e_beq_t, e_beq_nt;

    logic [13:0] act;
    assign act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                  alu_src_b, alu_op, reg_write, illegal_op};

    string       name_q[$];
    logic [13:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            string       nm;
            logic [13:0] ex;
            nm = name_q.pop_front();
            ex = exp_q.pop_front();
            n_cmp++;
            if (act !== ex) begin
                n_bad++;
                $display("FAIL %s: got %b expected %b", nm, act, ex);
            end else begin
                $display("ok   %s: %b", nm, act);
            end
        end
    end

    // Drive one cycle's inputs (from posedge+1) and queue that cycle's expected outputs
    task automatic cyc(input string nm, input logic [6:0] o, input logic z,
                       input logic mr, input logic [13:0] ex);
        op        = o;
        zero      = z;
        mem_ready = mr;
        name_q.push_back(nm);
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
    endtask

    initial begin
        e_zero        = mk(0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0);
        e_fetch       = mk(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,0);
        e_fetch_stall = mk(0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,0);
        e_decode      = mk(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,0);
        e_decode_ill  = mk(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,1);
        e_memadr      = mk(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,0);
        e_memread     = mk(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,0);
        e_memwb       = mk(0,0,0,0,2'b01,2'b00,2'b00,2'b00,1,0);
        e_memwrite    = mk(0,1,1,0,2'b00,2'b00,2'b00,2'b00,0,0);
        e_exec_r      = mk(0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,0);
        e_exec_i      = mk(0,0,0,0,2'b00,2'b10,2'b01,2'b10,0,0);
        e_aluwb       = mk(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,0);
        e_jal         = mk(1,0,0,0,2'b00,2'b01,2'b10,2'b00,0,0);
        e_beq_t       = mk(1,0,0,0,2'b00,2'b10,2'b00,2'b01,0,0);
        e_beq_nt      = mk(0,0,0,0,2'b00,2'b10,2'b00,2'b01,0,0);

        rst_n = 1'b0; op = '0; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cyc("reset_held", LW, 1'b1, 1'b1, e_zero);
        rst_n = 1'b1;
        cyc("reset_state", LW, 1'b1, 1'b1, e_zero);

        // lw, with one memory stall and an op change ignored in MEMREAD
        cyc("lw_fetch",    LW, 0, 1, e_fetch);
        cyc("lw_decode",   LW, 0, 1, e_decode);
        cyc("lw_memadr",   LW, 0, 1, e_memadr);
        cyc("lw_rd_stall", BAD, 0, 0, e_memread);
        cyc("lw_memread",  SW, 0, 1, e_memread);
        cyc("lw_memwb",    SW, 0, 1, e_memwb);

        // sw with mem_ready low for three cycles in MEMWRITE
        cyc("sw_fetch",    SW, 0, 1, e_fetch);
        cyc("sw_decode",   SW, 0, 1, e_decode);
        cyc("sw_memadr",   SW, 0, 1, e_memadr);
        cyc("sw_wr_w1",    SW, 0, 0, e_memwrite);
        cyc("sw_wr_w2",    SW, 0, 0, e_memwrite);
        cyc("sw_wr_w3",    SW, 0, 0, e_memwrite);
        cyc("sw_wr_done",  SW, 0, 1, e_memwrite);

        // R-type preceded by a two-cycle fetch stall
        cyc("r_fetch_st1", RT, 0, 0, e_fetch_stall);
        cyc("r_fetch_st2", RT, 0, 0, e_fetch_stall);
        cyc("r_fetch",     RT, 0, 1, e_fetch);
        cyc("r_decode",    RT, 0, 1, e_decode);
        cyc("r_exec",      RT, 0, 1, e_exec_r);
        cyc("r_aluwb",     RT, 0, 1, e_aluwb);

        cyc("i_fetch",     IT, 0, 1, e_fetch);
        cyc("i_decode",    IT, 0, 1, e_decode);
        cyc("i_exec",      IT, 0, 1, e_exec_i);
        cyc("i_aluwb",     IT, 0, 1, e_aluwb);

        cyc("jal_fetch",   JL, 0, 1, e_fetch);
        cyc("jal_decode",  JL, 0, 1, e_decode);
        cyc("jal_jal",     JL, 0, 1, e_jal);
        cyc("jal_aluwb",   JL, 0, 1, e_aluwb);

        // zero high outside BEQ must not write the PC
        cyc("beqt_fetch",  BQ, 1, 1, e_fetch);
        cyc("beqt_decode", BQ, 1, 1, e_decode);
        cyc("beqt_beq",    BQ, 1, 1, e_beq_t);
        cyc("beqn_fetch",  BQ, 0, 1, e_fetch);
        cyc("beqn_decode", BQ, 0, 1, e_decode);
        cyc("beqn_beq",    BQ, 0, 1, e_beq_nt);

        cyc("ill_fetch",   BAD, 0, 1, e_fetch);
        cyc("ill_decode",  BAD, 0, 1, e_decode_ill);
        cyc("ill_refetch", LW, 0, 0, e_fetch_stall);
        cyc("ab_fetch",    LW, 0, 1, e_fetch);

        // async reset while in MEMADR aborts the load with outputs forced low
        cyc("ab_decode",   LW, 0, 1, e_decode);
        rst_n = 1'b0;
        cyc("ab_reset",    LW, 0, 1, e_zero);
        rst_n = 1'b1;
        cyc("ab_reset_st", LW, 0, 1, e_zero);
        cyc("ab_fetch2",   LW, 0, 1, e_fetch);
        cyc("ab_decode2",  LW, 0, 1, e_decode);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
